bcd2bin: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the team's combinational `bin2bcd` block. It accepts four BCD digits (thousands, hundreds, tens, ones) on a start strobe and runs a reverse double-dabble algorithm, one bit per clock. It returns a SIZE-bit binary value with a done pulse and an error flag. It sits between keypad or switch digit-entry logic and arithmetic datapaths on the Basys3 designs.

---
 rtl/bcd2bin.sv | 132 +++++++++++++
 tb/tb_bcd2bin.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin.sv
// bcd2bin -- sequential BCD-to-binary converter (reverse double-dabble).
//
// Four BCD digits are captured on a start strobe.  The converter then shifts
// one bit per clock out of the BCD register into a 14-bit binary accumulator
// for 14 iterations. It reports a SIZE-bit result with a one-cycle done pulse.
// Start-to-done latency is fixed at 15 clocks.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; aborts any conversion silently
//   start      conversion request, honoured only in IDLE
//   thousands  BCD digit, weight 1000
//   hundreds   BCD digit, weight 100
//   tens       BCD digit, weight 10
//   ones       BCD digit, weight 1
//   bin_out    converted value, held until the next result
//   busy       high while iterating (CONV state)
//   done       one-cycle pulse when bin_out/err update
//   err        invalid digit (bin_out = 0) or overflow (bin_out saturated)
module bcd2bin #(
  parameter int SIZE = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      thousands,
  input  logic [3:0]      hundreds,
  input  logic [3:0]      tens,
  input  logic [3:0]      ones,
  output logic [SIZE-1:0] bin_out,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [14:0] MAX_VAL = 15'((1 << SIZE) - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] bcd_reg;
  logic [13:0] acc;
  logic [3:0]  cnt;
  logic        bad_digit;
  logic [29:0] shifted;
  logic [15:0] bcd_adj;

  // Reverse dabble correction: after a right shift, a nibble >= 8 holds a
  // half-ten that must become a half-eight, so subtract 3.
  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

  // Returns {err, bin_out}: invalid digits force zero, values beyond the
  // output width saturate to all ones.
  function automatic logic [SIZE:0] sat_result(input logic bad,
                                               input logic [13:0] v);
    if (bad)
      return {1'b1, {SIZE{1'b0}}};
    else if ({1'b0, v} > MAX_VAL)
      return {1'b1, {SIZE{1'b1}}};
    else
      return {1'b0, v[SIZE-1:0]};
  endfunction

  // One iteration: shift {bcd_reg, acc} right as a 30-bit unit, then
  // correct each BCD nibble independently on the post-shift value.
  always_comb begin
    shifted = {1'b0, bcd_reg, acc[13:1]};
    bcd_adj = {dabble(shifted[29:26]), dabble(shifted[25:22]),
               dabble(shifted[21:18]), dabble(shifted[17:14])};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == 4'd13) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CONV);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bcd_reg   <= '0;
      acc       <= '0;
      cnt       <= '0;
      bad_digit <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg   <= {thousands, hundreds, tens, ones};
            acc       <= '0;
            cnt       <= '0;
            bad_digit <= digit_bad(thousands) | digit_bad(hundreds) |
                         digit_bad(tens) | digit_bad(ones);
          end
        end
        CONV: begin
          bcd_reg <= bcd_adj;
          acc     <= shifted[13:0];
          cnt     <= cnt + 4'd1;
        end
        DONE: begin
          {err, bin_out} <= sat_result(bad_digit, acc);
          done           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Testbench for bcd2bin: drives a SIZE=14 and a SIZE=8 instance with the same
// digit stream; a scoreboard queue holds expected results and arrival cycles.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  th, hu, te, on;
  logic [13:0] bin14;
  logic        busy14, done14, err14;
  logic [7:0]  bin8;
  logic        busy8, done8, err8;

  always #5 clk = ~clk;

  bcd2bin #(.SIZE(14)) dut14 (
    .clk(clk), .reset(reset), .start(start),
    .thousands(th), .hundreds(hu), .tens(te), .ones(on),
    .bin_out(bin14), .busy(busy14), .done(done14), .err(err14)
  );

  bcd2bin #(.SIZE(8)) dut8 (
    .clk(clk), .reset(reset), .start(start),
    .thousands(th), .hundreds(hu), .tens(te), .ones(on),
    .bin_out(bin8), .busy(busy8), .done(done8), .err(err8)
  );

  typedef struct {
    logic [13:0] b14;
    logic        e14;
    logic [7:0]  b8;
    logic        e8;
    int          at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   fails = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, b, c, d, input int at);
    exp_t e;
    int   v;
    v = 1000 * int'(a) + 100 * int'(b) + 10 * int'(c) + int'(d);
    e.at = at;
    if (a > 9 || b > 9 || c > 9 || d > 9) begin
      e.b14 = '0; e.e14 = 1'b1; e.b8 = '0; e.e8 = 1'b1;
    end else begin
      e.b14 = 14'(v); e.e14 = 1'b0;
      if (v > 255) begin e.b8 = 8'hFF; e.e8 = 1'b1; end
      else begin e.b8 = 8'(v); e.e8 = 1'b0; end
    end
    return e;
  endfunction

  // Monitor: pop and compare whenever the SIZE=14 instance pulses done.
  initial begin
    exp_t e;
    bit   last_done;
    last_done = 1'b0;
    forever begin
      @(negedge clk);
      if (last_done) check("done_width", 32'(done14), 32'd0);
      last_done = done14;
      if (done14) begin
        done_cnt++;
        check("done_expected", 32'(q.size() != 0), 32'd1);
        check("busy_done_excl", 32'(busy14), 32'd0);
        check("done8_align", 32'(done8), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("latency", 32'(cyc), 32'(e.at));
          check("bin14", 32'(bin14), 32'(e.b14));
          check("err14", 32'(err14), 32'(e.e14));
          check("bin8", 32'(bin8), 32'(e.b8));
          check("err8", 32'(err8), 32'(e.e8));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents digits with start for one edge (T0); done is due 16 edges later.
  task automatic launch(input logic [3:0] a, b, c, d, input bit scored);
    th = a; hu = b; te = c; on = d;
    start = 1'b1;
    if (scored) q.push_back(model(a, b, c, d, cyc + 16));
    step(1);
    start = 1'b0;
  endtask

  task automatic convert(input logic [3:0] a, b, c, d);
    launch(a, b, c, d, 1'b1);
    step(15);
  endtask

  initial begin
    int saved;
    reset = 1'b1; start = 1'b0;
    th = '0; hu = '0; te = '0; on = '0;
    step(3);
    check("rst_bin14", 32'(bin14), 32'd0);
    check("rst_err14", 32'(err14), 32'd0);
    check("rst_done14", 32'(done14), 32'd0);
    check("rst_busy14", 32'(busy14), 32'd0);
    check("rst_bin8", 32'(bin8), 32'd0);
    reset = 1'b0;
    step(1);

    // Directed values and boundaries.
    convert(4'd9, 4'd9, 4'd9, 4'd9);
    convert(4'd0, 4'd0, 4'd1, 4'd0);
    convert(4'd0, 4'd0, 4'd0, 4'd0);
    convert(4'd0, 4'd2, 4'd5, 4'd5);
    convert(4'd0, 4'd2, 4'd5, 4'd6);
    convert(4'd1, 4'd0, 4'd0, 4'd0);
    convert(4'd0, 4'd0, 4'd0, 4'd1);
    convert(4'd8, 4'd1, 4'd9, 4'd1);
    convert(4'd0, 4'd0, 4'hA, 4'd0);
    convert(4'd0, 4'd1, 4'd2, 4'd3);
    convert(4'hF, 4'd0, 4'd0, 4'd0);
    convert(4'd0, 4'd0, 4'd0, 4'hC);

    // Random valid digits, back to back at minimum spacing.
    for (int i = 0; i < 30; i++)
      convert(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));

    // Handshake: digits change after capture, start pulsed in CONV and DONE.
    launch(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    th = 4'd9; hu = 4'd9; te = 4'd9; on = 4'd9;
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(11);
    start = 1'b1;
    step(1);
    start = 1'b0;

    // Reset at T0+7 aborts without a done pulse.
    launch(4'd5, 4'd5, 4'd5, 4'd5, 1'b0);
    step(6);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("abort_busy14", 32'(busy14), 32'd0);
    check("abort_bin14", 32'(bin14), 32'd0);
    check("abort_err8", 32'(err8), 32'd0);
    check("abort_bin8", 32'(bin8), 32'd0);
    check("abort_busy8", 32'(busy8), 32'd0);
    saved = done_cnt;
    step(20);
    check("abort_no_done", 32'(done_cnt), 32'(saved));
    convert(4'd4, 4'd3, 4'd2, 4'd1);

    for (int i = 0; i < 40 && q.size() != 0; i++) step(1);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
